port_reader: RTL
================

PORT_READER -- requirements
Module: port_reader

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, CPU port data/address width.
REQ-002 SHALL have parameter DEBOUNCE_BITS, default 16, debounce counter width; a button must be stable for 2^DEBOUNCE_BITS mclk cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, press-event FIFO entries (power of two, 2..16).
REQ-004 SHALL have port mclk input 1: the single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n input 1: asynchronous, active-low reset.
REQ-006 SHALL have port portaddr input WORD_SIZE: CPU port address, stable while portget high.
REQ-007 SHALL have port portget input 1: CPU read strobe, asynchronous to mclk (CPU-clock domain).
REQ-008 SHALL have port sw input 8: raw board switches.
REQ-009 SHALL have port btn input 4: raw board buttons, active-high.
REQ-010 SHALL have port portout output WORD_SIZE: read data returned to the CPU.

Function
REQ-011 SHALL pass sw, btn, portget each through a two-flop synchronizer before any use.
REQ-012 SHALL detect a read as a synchronized-portget rising edge; portout updated exactly 1 mclk after that edge is seen (3 mclk after the raw edge), held until the next read.
REQ-013 SHALL decode portaddr[1:0]: 0 = SWITCH, 1 = EVENT, 2 = STATUS, 3 = returns 0; upper address bits ignored.
REQ-014 SWITCH read SHALL return {zeros, synchronized sw[7:0]}.
REQ-015 EVENT read SHALL pop FIFO head, returning bit15=1, bits3:0=button mask, others 0; on empty SHALL return 0x0000 with no pointer change.
REQ-016 STATUS read SHALL return bits4:0 = FIFO count, bit8 = overflow flag, others 0; the read clears overflow.
REQ-017 Per button, a debounced level SHALL change only after the synchronized input differs from it for 2^DEBOUNCE_BITS consecutive cycles; counter restarts on any bounce.
REQ-018 A debounced 0->1 transition on one or more buttons in the same cycle SHALL push one entry holding the mask of all rising buttons.
REQ-019 Push when full SHALL drop the entry and set overflow; overflow stays set until a STATUS read.
REQ-020 Simultaneous push and pop SHALL both occur; count unchanged; if full, the push is accepted (no overflow) since a slot frees that cycle.
REQ-021 Simultaneous push-overflow and STATUS read SHALL leave overflow set (set wins).
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-023 reset_n low SHALL immediately clear portout to 0, FIFO pointers/count, overflow, debounce counters and levels, and synchronizer flops.
REQ-024 Reset asserted mid-read SHALL abort it; a portget still high at release SHALL NOT be treated as a new edge.

Configuration
REQ-025 With PORT_READER_DEBOUNCE_EN defined, SHALL debounce per REQ-017.
REQ-026 Without PORT_READER_DEBOUNCE_EN, debounced level SHALL equal synchronized btn directly; DEBOUNCE_BITS unused; no counters instantiated.

Structure
REQ-027 WORD_SIZE and the port address constants (SWITCH, EVENT, STATUS) SHALL live in the shared parameters include.
REQ-028 Per-button debounce SHALL be one sub-module, btn_debounce, instantiated four times.

Verification
REQ-029 sw=0xA5, pulse portget with portaddr=0 -> portout=0x00A5 three mclk after raw edge.
REQ-030 Press btn[2] clean for 2^DEBOUNCE_BITS+4 cycles, read addr 1 -> 0x8004; read addr 1 again -> 0x0000.
REQ-031 With debounce enabled, toggle btn[0] every 100 cycles (DEBOUNCE_BITS=8) -> no entry; STATUS=0x0000.
REQ-032 Five separate presses of btn[1] (depth 4), read addr 2 -> 0x0104; read again -> 0x0004.
REQ-033 FIFO full, EVENT pop in same cycle as new btn[3] press -> no overflow; STATUS=0x0004; last popped entry later = 0x8008.
REQ-034 Assert reset_n low while portget high with 2 entries queued -> portout=0, STATUS read after release=0x0000, no spurious pop.

Source files
------------

// File: rtl/port_reader_pkg.sv
//------------------------------------------------------------------------------
// Module   : port_reader_pkg
// Brief    : Shared parameters for the CPU input-port reader: default data
//            width, port address map and readout bit positions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package port_reader_pkg;

  // Default CPU port data/address width
  localparam int PR_WORD_SIZE = 16;

  // Port address map, decoded from portaddr[1:0] only
  typedef enum logic [1:0] {
    ADDR_SWITCH = 2'd0,
    ADDR_EVENT  = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_NONE   = 2'd3
  } port_addr_e;

  // Readout bit positions
  localparam int EVENT_VALID_BIT = 15;
  localparam int STATUS_OVF_BIT  = 8;
  localparam int STATUS_CNT_W    = 5;

endpackage

`default_nettype wire

// File: rtl/port_reader_btn_debounce.sv
//------------------------------------------------------------------------------
// Module   : btn_debounce
// Brief    : Single-button debouncer. The output level follows the (already
//            synchronized) input only after the input has disagreed with it
//            for 2^DEBOUNCE_BITS consecutive cycles; any bounce restarts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic mclk,
  input  logic reset_n,
  input  logic din,
  output logic level
);

  logic [DEBOUNCE_BITS-1:0] stable_cnt;
  logic                     level_q;

  // Count consecutive disagreeing cycles; flip the level when the count saturates
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      level_q    <= 1'b0;
    end else if (din == level_q) begin
      stable_cnt <= '0;
    end else if (&stable_cnt) begin
      level_q    <= din;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/port_reader.sv
//------------------------------------------------------------------------------
// Module   : port_reader
// Brief    : Memory-mapped input port for a CPU. Synchronizes switches,
//            buttons and the CPU read strobe into mclk, queues button press
//            events in a small FIFO and answers reads of SWITCH / EVENT /
//            STATUS registers.
// Options  : define PORT_READER_DEBOUNCE_EN to debounce each button through
//            btn_debounce; otherwise the synchronized button is used directly.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module port_reader
  import port_reader_pkg::*;
#(
  parameter int WORD_SIZE     = PR_WORD_SIZE,
  parameter int DEBOUNCE_BITS = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic                 portget,
  input  logic [7:0]           sw,
  input  logic [3:0]           btn,
  output logic [WORD_SIZE-1:0] portout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [STATUS_CNT_W-1:0] FULL_COUNT = STATUS_CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [7:0] sw_s1, sw_s2;
  logic [3:0] btn_s1, btn_s2;
  logic       pg_s1, pg_s2, pg_s3;
  // Marks which portget pipeline stages hold real samples since reset, so a
  // strobe already high at reset release is not mistaken for a new edge.
  logic [2:0] pg_valid;

  // Two-flop synchronizers plus one history flop for portget edge detection
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      pg_s1    <= 1'b0;
      pg_s2    <= 1'b0;
      pg_s3    <= 1'b0;
      pg_valid <= '0;
    end else begin
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      pg_s1    <= portget;
      pg_s2    <= pg_s1;
      pg_s3    <= pg_s2;
      pg_valid <= {pg_valid[1:0], 1'b1};
    end
  end

  logic read_pulse;
  assign read_pulse = pg_s2 & ~pg_s3 & pg_valid[2];

  // ---------------------------------------------------------------------------
  // Button levels (debounced or direct)
  // ---------------------------------------------------------------------------
  logic [3:0] btn_level;
  logic [3:0] btn_level_q;

`ifdef PORT_READER_DEBOUNCE_EN
  for (genvar i = 0; i < 4; i++) begin : g_debounce
    btn_debounce #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_btn_debounce (
      .mclk    (mclk),
      .reset_n (reset_n),
      .din     (btn_s2[i]),
      .level   (btn_level[i])
    );
  end
`else
  localparam int unused_debounce_bits = DEBOUNCE_BITS;
  assign btn_level = btn_s2;
`endif

  // Previous button level, for rising-edge detection
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      btn_level_q <= '0;
    end else begin
      btn_level_q <= btn_level;
    end
  end

  logic [3:0] rise_mask;
  logic       push;
  assign rise_mask = btn_level & ~btn_level_q;
  assign push      = |rise_mask;

  // ---------------------------------------------------------------------------
  // Press-event FIFO
  // ---------------------------------------------------------------------------
  logic [3:0]              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [STATUS_CNT_W-1:0] count;
  logic                    overflow;

  port_addr_e addr_sel;
  logic       is_empty, is_full;
  logic       pop, push_ok, ovf_set, status_rd;

  assign addr_sel  = port_addr_e'(portaddr[1:0]);
  assign is_empty  = (count == '0);
  assign is_full   = (count == FULL_COUNT);
  assign pop       = read_pulse && (addr_sel == ADDR_EVENT) && !is_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits
  assign push_ok   = push && (!is_full || pop);
  assign ovf_set   = push && is_full && !pop;
  assign status_rd = read_pulse && (addr_sel == ADDR_STATUS);

  // FIFO storage, pointers, occupancy and sticky overflow flag
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= rise_mask;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Setting wins over the clear from a simultaneous STATUS read
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data mux and output register
  // ---------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] read_data;

  // Select the register addressed by portaddr[1:0]
  always_comb begin
    read_data = '0;
    case (addr_sel)
      ADDR_SWITCH: begin
        read_data[7:0] = sw_s2;
      end
      ADDR_EVENT: begin
        if (!is_empty) begin
          read_data[EVENT_VALID_BIT] = 1'b1;
          read_data[3:0]             = fifo_mem[rd_ptr];
        end
      end
      ADDR_STATUS: begin
        read_data[STATUS_CNT_W-1:0] = count;
        read_data[STATUS_OVF_BIT]   = overflow;
      end
      default: begin
        read_data = '0;
      end
    endcase
  end

  // Capture read data one cycle after the synchronized strobe edge; hold otherwise
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      portout <= '0;
    end else if (read_pulse) begin
      portout <= read_data;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^portaddr[WORD_SIZE-1:2];

endmodule

`default_nettype wire
